// File: rtl/mult_rr_sched.sv
// Round-robin front end that time-shares one sequential 4x4 multiplier among NREQ requesters.
// Every output is a register; a job that never completes is retired with rsp_err after TIMEOUT wait cycles.
module mult_rr_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31,
  parameter int TW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              mult_init,
  output logic [3:0]        mult_a,
  output logic [3:0]        mult_b,
  input  logic              mult_done,
  input  logic [7:0]        mult_pp
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t            state, state_d;
  logic [IW-1:0]     ptr, ptr_d;
  logic [IW-1:0]     idx, idx_d;
  logic [TW-1:0]     timer, timer_d;
  logic [NREQ-1:0]   gnt_d, rsp_valid_d;
  logic [7:0]        rsp_data_d;
  logic              rsp_err_d, busy_d, mult_init_d;
  logic [3:0]        mult_a_d, mult_b_d;
  logic [IW-1:0]     sel, cand;

  // Walk from the farthest candidate back towards ptr so the nearest pending requester wins.
  always_comb begin
    sel  = ptr;
    cand = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) sel = cand;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    idx_d       = idx;
    timer_d     = timer;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = 1'b0;
    mult_init_d = 1'b0;
    mult_a_d    = mult_a;
    mult_b_d    = mult_b;

    case (state)
      IDLE: begin
        if (|req) begin
          idx_d        = sel;
          gnt_d[sel]   = 1'b1;
          mult_init_d  = 1'b1;
          mult_a_d     = a_in[4*sel +: 4];
          mult_b_d     = b_in[4*sel +: 4];
          state_d      = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW, WAIT_HIGH: begin
        // An accepted done beats a timeout landing in the same cycle.
        if (state == WAIT_HIGH && mult_done) begin
          rsp_data_d       = mult_pp;
          rsp_valid_d[idx] = 1'b1;
          state_d          = RESP;
        end else if (timer == TW'(TIMEOUT)) begin
          rsp_data_d       = '0;
          rsp_err_d        = 1'b1;
          rsp_valid_d[idx] = 1'b1;
          state_d          = RESP;
        end else begin
          timer_d = timer + 1'b1;
          if (state == WAIT_LOW && !mult_done) state_d = WAIT_HIGH;
        end
      end
      RESP: begin
        ptr_d   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      timer     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mult_init <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      idx       <= idx_d;
      timer     <= timer_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      mult_init <= mult_init_d;
      mult_a    <= mult_a_d;
      mult_b    <= mult_b_d;
    end
  end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Scoreboard bench for mult_rr_sched: a predictor queues the expected response per grant,
// a monitor pops and compares on rsp_valid; a behavioural multiplier with variable latency sits on the mult port.
module tb_mult_rr_sched;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;
  localparam int TW      = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err, busy, mult_init;
  logic [3:0]        mult_a, mult_b;
  logic              mult_done;
  logic [7:0]        mult_pp;

  mult_rr_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mult_init(mult_init), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_pp(mult_pp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
    bit err;
    int gcyc;
  } exp_t;

  exp_t            exp_q[$];
  logic [NREQ-1:0] gnt_log[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  bit              stuck = 1'b0;
  int              force_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nib(input logic [4*NREQ-1:0] v, input int i);
    logic [4*NREQ-1:0] s;
    s = v >> (4 * i);
    return int'(s[3:0]);
  endfunction

  function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic set_ops(input int i, input int a, input int b);
    logic [4*NREQ-1:0] m, av, bv;
    m  = {{(4*NREQ-4){1'b0}}, 4'hF} << (4 * i);
    av = {{(4*NREQ-4){1'b0}}, 4'(a)} << (4 * i);
    bv = {{(4*NREQ-4){1'b0}}, 4'(b)} << (4 * i);
    a_in = (a_in & ~m) | av;
    b_in = (b_in & ~m) | bv;
  endtask

  // Inputs as seen by the design at the most recent rising edge.
  logic [NREQ-1:0]   req_s;
  logic [4*NREQ-1:0] a_s, b_s;
  always @(posedge clk) begin
    req_s <= req;
    a_s   <= a_in;
    b_s   <= b_in;
    cyc   <= cyc + 1;
  end

  // Behavioural multiplier: done drops the cycle after init, rises after a random latency; stuck mode pins done high.
  int       m_cnt;
  logic [3:0] m_a, m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_done <= 1'b0;
      mult_pp   <= '0;
      m_cnt     <= 0;
      m_a       <= '0;
      m_b       <= '0;
    end else if (stuck) begin
      mult_done <= 1'b1;
    end else if (mult_init) begin
      mult_done <= 1'b0;
      m_cnt     <= (force_lat != 0) ? force_lat : int'($urandom_range(1, 8));
      m_a       <= mult_a;
      m_b       <= mult_b;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mult_done <= 1'b1;
        mult_pp   <= 8'(m_a) * 8'(m_b);
      end
    end
  end

  // Predictor: round-robin reference over the sampled request vector, one expected response per grant.
  int m_ptr = 0;
  int e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (mult_init || gnt != 0) check("init_with_gnt", 32'(mult_init), 32'(gnt != 0));
      if (gnt != 0) begin
        e = -1;
        for (int k = 0; k < NREQ; k++)
          if (e < 0 && bit_at(req_s, (m_ptr + k) % NREQ)) e = (m_ptr + k) % NREQ;
        if (e < 0) begin
          check("gnt_without_req", 32'(gnt), 0);
        end else begin
          check("gnt", 32'(gnt), 32'(1) << e);
          check("mult_a", 32'(mult_a), nib(a_s, e));
          check("mult_b", 32'(mult_b), nib(b_s, e));
          exp_q.push_back('{idx: e, data: stuck ? 0 : nib(a_s, e) * nib(b_s, e), err: stuck, gcyc: cyc});
          m_ptr = (e + 1) % NREQ;
        end
      end
    end
  end

  // Monitor: pops on every response and compares it with the oldest expectation.
  exp_t x;
  int   wd = 0;
  bit   prev_rsp = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      wd       = 0;
      prev_rsp = 1'b0;
    end else begin
      if (prev_rsp) check("busy_after_resp", 32'(busy), 0);
      prev_rsp = (rsp_valid != 0);
      if (rsp_valid != 0) begin
        wd = 0;
        check("busy_in_resp", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          x = exp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1) << x.idx);
          check("rsp_data", 32'(rsp_data), 32'(x.data));
          check("rsp_err", 32'(rsp_err), 32'(x.err));
          if (x.err) check("timeout_latency", 32'(cyc - x.gcyc), 32'(TIMEOUT + 2));
        end
      end else if (exp_q.size() != 0) begin
        wd++;
        if (wd > 200) begin
          check("rsp_watchdog", 32'(wd), 0);
          exp_q.delete();
          wd = 0;
        end
      end else begin
        wd = 0;
      end
    end
  end

  // Requesters drop their line on the cycle they see their response.
  task automatic wait_drain(input int max_cyc, input bit rand_ops);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (gnt != 0) gnt_log.push_back(gnt);
      req = req & ~rsp_valid;
      if (rand_ops) begin
        a_in = 16'($urandom);
        b_in = 16'($urandom);
      end
      n++;
    end while ((req != 0 || busy) && n < max_cyc);
    check("drain_bound", 32'(n >= max_cyc), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] fair_exp [5];
    int n;
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mult_init", 32'(mult_init), 0);
    check("rst_mult_a", 32'(mult_a), 0);
    check("rst_mult_b", 32'(mult_b), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness with every line held: 0,1,2,3 then back to 0.
    for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 2);
    req = '1;
    gnt_log.delete();
    n = 0;
    while (gnt_log.size() < 5 && n < 400) begin
      @(negedge clk);
      if (gnt != 0) gnt_log.push_back(gnt);
      n++;
    end
    req = '0;
    for (int i = 0; i < 5; i++)
      check("fair_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF, 32'(fair_exp[i]));
    wait_drain(200, 1'b0);

    // Single job: grant one cycle after the request.
    set_ops(0, 3, 5);
    req = 4'b0001;
    @(negedge clk);
    check("gnt_latency", 32'(gnt), 32'b0001);
    wait_drain(100, 1'b0);

    // Largest operands.
    set_ops(2, 15, 15);
    req = 4'b0100;
    wait_drain(100, 1'b0);

    // Serve 3, then both ends of the ring: 0 must come before 3.
    set_ops(3, 6, 7);
    req = 4'b1000;
    wait_drain(100, 1'b0);
    set_ops(0, 9, 9);
    req = 4'b1001;
    gnt_log.delete();
    wait_drain(200, 1'b0);
    check("wrap_first", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF, 32'b0001);
    check("wrap_second", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'hFFFF, 32'b1000);

    // Done stuck high: job must time out, the next one must complete normally.
    stuck = 1'b1;
    @(negedge clk);
    set_ops(1, 4, 4);
    req = 4'b0010;
    wait_drain(300, 1'b0);
    stuck = 1'b0;
    set_ops(0, 7, 9);
    req = 4'b0001;
    wait_drain(100, 1'b0);

    // Reset while waiting for a slow done.
    force_lat = 12;
    set_ops(2, 5, 6);
    req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < 10);
    check("pre_reset_gnt", 32'(gnt), 32'b0100);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_rsp_data", 32'(rsp_data), 0);
    check("mid_rst_rsp_err", 32'(rsp_err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_mult_init", 32'(mult_init), 0);
    check("mid_rst_mult_a", 32'(mult_a), 0);
    check("mid_rst_mult_b", 32'(mult_b), 0);
    req = '0;
    repeat (2) @(negedge clk);
    force_lat = 0;
    set_ops(1, 9, 13);
    req = 4'b0010;
    rst = 1'b0;
    gnt_log.delete();
    wait_drain(100, 1'b0);
    check("post_rst_gnt", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF, 32'b0010);

    // Random traffic with operands changing every cycle.
    repeat (600) begin
      @(negedge clk);
      req  = (req & ~rsp_valid) | (NREQ'($urandom) & NREQ'($urandom));
      a_in = 16'($urandom);
      b_in = 16'($urandom);
    end
    wait_drain(2000, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
